onehot_to_index: RTL and testbench

- Converts a NUM_SIGNALS-bit one-hot vector into its binary index.
- Used by CAMs, arbiters and way-select logic to turn one-hot hit/grant vectors into indices.
- Provides two output sets:
  - a zero-latency combinational result;
  - a one-cycle registered copy with async reset, for timing-critical consumers.
- Also flags empty (no bit set) and multi-hot (more than one bit set) inputs.

---
 rtl/onehot_to_index.sv | 113 +++++++++++
 tb/tb_onehot_to_index.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_to_index.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_index
//  Description : Converts a one-hot vector into its binary index. Provides a
//                zero-latency combinational result plus a registered copy
//                (asynchronous active-high reset, load enable). Also flags
//                empty and multi-hot inputs.
//                Optional macro ONEHOT_TO_INDEX_PRIORITY_EN: when defined,
//                multi-hot inputs resolve to the lowest-numbered set bit;
//                when undefined, the index is the OR of all set bits'
//                mapped indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_index #(
    parameter int NUM_SIGNALS = 4,
    parameter     DIRECTION   = "LSB0",
    parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   any_set,
    output logic                   multi_hot,
    input  logic                   reg_en,
    output logic [INDEX_WIDTH-1:0] index_q,
    output logic                   any_set_q,
    output logic                   multi_hot_q
);

    localparam bit c_MSB0 = (DIRECTION == "MSB0");

    // Mapped index of every input bit, already fitted to INDEX_WIDTH.
    logic [INDEX_WIDTH-1:0] w_map [NUM_SIGNALS];

    logic [INDEX_WIDTH-1:0] w_index;
    logic                   w_any_set;
    logic                   w_multi_hot;

    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_any_set;
    logic                   r_multi_hot;

    generate
        for (genvar i = 0; i < NUM_SIGNALS; i++) begin : g_map
            localparam int c_MAPPED = c_MSB0 ? (NUM_SIGNALS - 1 - i) : i;
            assign w_map[i] = INDEX_WIDTH'(c_MAPPED);
        end
    endgenerate

`ifdef ONEHOT_TO_INDEX_PRIORITY_EN
    // Priority encode: the lowest-numbered set bit supplies the index.
    always_comb begin
        logic found;
        w_index = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i] && !found) begin
                w_index = w_map[i];
                found   = 1'b1;
            end
        end
    end
`else
    // OR-reduction encode: every set bit ORs in its mapped index.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i]) begin
                w_index = w_index | w_map[i];
            end
        end
    end
`endif

    // Empty / multi-hot detection: a second set bit after any earlier one.
    always_comb begin
        logic seen;
        seen        = 1'b0;
        w_multi_hot = 1'b0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i]) begin
                if (seen) begin
                    w_multi_hot = 1'b1;
                end
                seen = 1'b1;
            end
        end
        w_any_set = |one_hot;
    end

    // Registered copy: async clear, load on enable, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index     <= '0;
            r_any_set   <= 1'b0;
            r_multi_hot <= 1'b0;
        end else if (reg_en) begin
            r_index     <= w_index;
            r_any_set   <= w_any_set;
            r_multi_hot <= w_multi_hot;
        end
    end

    assign index       = w_index;
    assign any_set     = w_any_set;
    assign multi_hot   = w_multi_hot;
    assign index_q     = r_index;
    assign any_set_q   = r_any_set;
    assign multi_hot_q = r_multi_hot;

endmodule
`default_nettype wire

// File: tb/tb_onehot_to_index.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_to_index
//  Description : Self-checking bench for onehot_to_index. Three instances with
//                NUM_SIGNALS=8: LSB0, MSB0, and LSB0 with a 2-bit index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_to_index;

    logic       clk;
    logic       reset;
    logic [7:0] one_hot;
    logic       reg_en;

    logic [2:0] idx_l, idxq_l, idx_m, idxq_m;
    logic       any_l, anyq_l, mh_l, mhq_l;
    logic       any_m, anyq_m, mh_m, mhq_m;
    logic [1:0] idx_t, idxq_t;
    logic       any_t, anyq_t, mh_t, mhq_t;

    int total_count = 0;
    int pass_count  = 0;

    onehot_to_index #(.NUM_SIGNALS(8), .DIRECTION("LSB0")) u_lsb (
        .clk(clk), .reset(reset), .one_hot(one_hot), .index(idx_l),
        .any_set(any_l), .multi_hot(mh_l), .reg_en(reg_en),
        .index_q(idxq_l), .any_set_q(anyq_l), .multi_hot_q(mhq_l)
    );

    onehot_to_index #(.NUM_SIGNALS(8), .DIRECTION("MSB0")) u_msb (
        .clk(clk), .reset(reset), .one_hot(one_hot), .index(idx_m),
        .any_set(any_m), .multi_hot(mh_m), .reg_en(reg_en),
        .index_q(idxq_m), .any_set_q(anyq_m), .multi_hot_q(mhq_m)
    );

    onehot_to_index #(.NUM_SIGNALS(8), .DIRECTION("LSB0"), .INDEX_WIDTH(2)) u_trunc (
        .clk(clk), .reset(reset), .one_hot(one_hot), .index(idx_t),
        .any_set(any_t), .multi_hot(mh_t), .reg_en(reg_en),
        .index_q(idxq_t), .any_set_q(anyq_t), .multi_hot_q(mhq_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] oh;
        int         lsb_or;   // OR-reduction build expectations
        int         msb_or;
        int         tr_or;
        int         lsb_pr;   // priority build expectations
        int         msb_pr;
        int         tr_pr;
        logic       anys;
        logic       multi;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        //           oh     lsb msb tr  lsbP msbP trP any multi
        vecs[0]  = '{8'h00, 0,  0,  0,  0,   0,   0,  0,  0};
        vecs[1]  = '{8'h01, 0,  7,  0,  0,   7,   0,  1,  0};
        vecs[2]  = '{8'h02, 1,  6,  1,  1,   6,   1,  1,  0};
        vecs[3]  = '{8'h04, 2,  5,  2,  2,   5,   2,  1,  0};
        vecs[4]  = '{8'h08, 3,  4,  3,  3,   4,   3,  1,  0};
        vecs[5]  = '{8'h10, 4,  3,  0,  4,   3,   0,  1,  0};
        vecs[6]  = '{8'h20, 5,  2,  1,  5,   2,   1,  1,  0};
        vecs[7]  = '{8'h40, 6,  1,  2,  6,   1,   2,  1,  0};
        vecs[8]  = '{8'h80, 7,  0,  3,  7,   0,   3,  1,  0};
        vecs[9]  = '{8'h06, 3,  7,  3,  1,   6,   1,  1,  1};
        vecs[10] = '{8'h0A, 3,  6,  3,  1,   6,   1,  1,  1};
        vecs[11] = '{8'h11, 4,  7,  0,  0,   7,   0,  1,  1};
        vecs[12] = '{8'hFF, 7,  7,  3,  0,   7,   0,  1,  1};

        // Reset held high while the combinational table runs: clock edges
        // with reg_en=1 must not disturb the registered stage.
        reset   = 1'b1;
        reg_en  = 1'b1;
        one_hot = 8'h00;
        #2;
        check("reset_index_q", idxq_l, 0);
        check("reset_any_set_q", anyq_l, 0);
        check("reset_multi_hot_q", mhq_l, 0);

        for (int k = 0; k < 13; k++) begin
            one_hot = vecs[k].oh;
            #3;
`ifdef ONEHOT_TO_INDEX_PRIORITY_EN
            check($sformatf("lsb_index[%02h]", vecs[k].oh), idx_l, vecs[k].lsb_pr);
            check($sformatf("msb_index[%02h]", vecs[k].oh), idx_m, vecs[k].msb_pr);
            check($sformatf("trunc_index[%02h]", vecs[k].oh), idx_t, vecs[k].tr_pr);
`else
            check($sformatf("lsb_index[%02h]", vecs[k].oh), idx_l, vecs[k].lsb_or);
            check($sformatf("msb_index[%02h]", vecs[k].oh), idx_m, vecs[k].msb_or);
            check($sformatf("trunc_index[%02h]", vecs[k].oh), idx_t, vecs[k].tr_or);
`endif
            check($sformatf("any_set[%02h]", vecs[k].oh), any_l, vecs[k].anys);
            check($sformatf("multi_hot[%02h]", vecs[k].oh), mh_l, vecs[k].multi);
            check($sformatf("msb_multi_hot[%02h]", vecs[k].oh), mh_m, vecs[k].multi);
        end

        one_hot = 8'h20;
        repeat (2) @(posedge clk);
        #1;
        check("held_in_reset_index_q", idxq_l, 0);
        check("held_in_reset_any_set_q", anyq_l, 0);

        // Release reset and load 8'h20.
        @(negedge clk);
        reset   = 1'b0;
        reg_en  = 1'b1;
        one_hot = 8'h20;
        @(posedge clk);
        #1;
        check("load_index_q", idxq_l, 5);
        check("load_any_set_q", anyq_l, 1);
        check("load_multi_hot_q", mhq_l, 0);
        check("load_msb_index_q", idxq_m, 2);
        check("load_trunc_index_q", idxq_t, 1);

        // Hold for three edges with a different input.
        @(negedge clk);
        reg_en  = 1'b0;
        one_hot = 8'h01;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_index_q[%0d]", e), idxq_l, 5);
            check($sformatf("hold_any_set_q[%0d]", e), anyq_l, 1);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_index_q", idxq_l, 0);
        check("async_reset_any_set_q", anyq_l, 0);
        check("comb_during_reset_index", idx_l, 0);
        check("comb_during_reset_any_set", any_l, 1);

        @(negedge clk);
        reset   = 1'b0;
        reg_en  = 1'b1;
        one_hot = 8'h08;
        @(posedge clk);
        #1;
        check("post_reset_index_q", idxq_l, 3);
        check("post_reset_any_set_q", anyq_l, 1);

        // Multi-hot capture into the registered stage.
        @(negedge clk);
        one_hot = 8'h06;
        @(posedge clk);
        #1;
`ifdef ONEHOT_TO_INDEX_PRIORITY_EN
        check("multi_load_index_q", idxq_l, 1);
`else
        check("multi_load_index_q", idxq_l, 3);
`endif
        check("multi_load_multi_hot_q", mhq_l, 1);

        // Empty input loaded clears everything.
        @(negedge clk);
        one_hot = 8'h00;
        @(posedge clk);
        #1;
        check("empty_load_index_q", idxq_l, 0);
        check("empty_load_any_set_q", anyq_l, 0);
        check("empty_load_multi_hot_q", mhq_l, 0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
`default_nettype wire
